// File: rtl/mmio_pkg.sv
// Shared definitions for the data-memory responder and its timer peripheral.
// Latency: n/a (constants, types and a helper only).
// Backpressure: n/a.
package mmio_pkg;

    // Byte offsets (addr[7:0]) of the peripheral registers inside the MMIO page.
    localparam logic [7:0] OFF_LED    = 8'h00;
    localparam logic [7:0] OFF_CYCLE  = 8'h04;
    localparam logic [7:0] OFF_TLOAD  = 8'h08;
    localparam logic [7:0] OFF_TCOUNT = 8'h0C;
    localparam logic [7:0] OFF_TCTRL  = 8'h10;

    // Bit positions inside TIMER_CTRL.
    localparam int CTRL_EN  = 0;
    localparam int CTRL_AR  = 1;
    localparam int CTRL_EXP = 2;
    localparam int CTRL_IE  = 3;

    // Member order is MSB first, so the packed value lines up with bits [3:0].
    typedef struct packed {
        logic ie;
        logic expired;
        logic autoreload;
        logic en;
    } timer_ctrl_t;

    // Software view of TIMER_CTRL: bits [31:4] read as zero.
    function automatic logic [31:0] ctrl_to_word(input timer_ctrl_t c);
        return {28'd0, c};
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Down-counting timer with one-shot / auto-reload modes and a maskable expiry interrupt.
// Latency: register writes and count updates land on the rising edge; read values come straight from registers.
// Backpressure: none; a write strobe is always accepted in the cycle it is presented.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   load_we_i        write strobe for TIMER_LOAD (also reloads count)
//   ctrl_we_i        write strobe for TIMER_CTRL
//   wdata_i          store data shared by both strobes
//   load_o/count_o   current TIMER_LOAD / TIMER_COUNT values
//   ctrl_o           TIMER_CTRL read value
//   irq_o            expired AND ie
module mmio_timer
    import mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_we_i,
    input  logic        ctrl_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] count_o,
    output logic [31:0] ctrl_o,
    output logic        irq_o
);

    logic [31:0] load_q,  load_d;
    logic [31:0] count_q, count_d;
    timer_ctrl_t ctrl_q,  ctrl_d;
    logic        irq_q;

    always_comb begin
        load_d  = load_q;
        count_d = count_q;
        ctrl_d  = ctrl_q;

        // Software control write first: the newly written en/autoreload/ie are
        // the ones the countdown step below sees in this same cycle.
        if (ctrl_we_i) begin
            ctrl_d.en         = wdata_i[CTRL_EN];
            ctrl_d.autoreload = wdata_i[CTRL_AR];
            ctrl_d.ie         = wdata_i[CTRL_IE];
            if (wdata_i[CTRL_EXP]) begin
                ctrl_d.expired = 1'b0;
            end
        end

        // Countdown step. Expiry is applied after the clear above, so a
        // same-cycle expiry keeps the flag set. A count of 0 is a parked state.
        if (ctrl_d.en) begin
            if (count_q == 32'd1) begin
                ctrl_d.expired = 1'b1;
                if (ctrl_d.autoreload) begin
                    count_d = load_q;
                end else begin
                    count_d   = '0;
                    ctrl_d.en = 1'b0;
                end
            end else if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end
        end

        // A LOAD write overrides whatever the countdown chose for count.
        if (load_we_i) begin
            load_d  = wdata_i;
            count_d = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_q  <= '0;
            count_q <= '0;
            ctrl_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            load_q  <= load_d;
            count_q <= count_d;
            ctrl_q  <= ctrl_d;
            irq_q   <= ctrl_d.expired & ctrl_d.ie;
        end
    end

    assign load_o  = load_q;
    assign count_o = count_q;
    assign ctrl_o  = ctrl_to_word(ctrl_q);
    assign irq_o   = irq_q;

endmodule

// File: rtl/dmem_mmio.sv
// Data-side responder for a single-cycle core: word RAM plus LED, cycle counter and timer MMIO.
// Latency: reads are combinational from addr and current state; stores commit on the rising edge.
// Backpressure: none; every load and store completes in the cycle it is presented.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset (RAM contents survive reset)
//   memwrite     store strobe
//   addr         byte address; addr[1:0] ignored
//   writedata    store data
//   readdata     load data (RAM word, peripheral register, or 0 for unmapped)
//   leds         LED register
//   irq          timer interrupt
module dmem_mmio
    import mmio_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter              INIT_FILE = "",
    parameter logic [15:0] MMIO_BASE = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [15:0] leds,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic          mmio_sel;
    logic          ram_sel;
    logic [AW-1:0] widx;
    logic [7:0]    off;
    logic          mmio_we;
    logic          led_we;
    logic          tload_we;
    logic          tctrl_we;
    logic [15:0]   leds_q,  leds_d;
    logic [31:0]   cycle_q, cycle_d;
    logic [31:0]   tload_rd;
    logic [31:0]   tcount_rd;
    logic [31:0]   tctrl_rd;
    logic          unused_addr_lsb;

    // Byte-lane bits carry no meaning on this word-only bus.
    assign unused_addr_lsb = ^addr[1:0];

    // Decode. The RAM window is the low DEPTH words outside the MMIO page;
    // everything else outside the page is unmapped.
    assign mmio_sel = (addr[31:16] == MMIO_BASE);
    assign ram_sel  = !mmio_sel && (addr[31:2] < 30'(DEPTH));
    assign widx     = addr[AW+1:2];
    assign off      = {addr[7:2], 2'b00};

    assign mmio_we  = memwrite && mmio_sel;
    assign led_we   = mmio_we && (off == OFF_LED);
    assign tload_we = mmio_we && (off == OFF_TLOAD);
    assign tctrl_we = mmio_we && (off == OFF_TCTRL);

    // RAM write port; no reset so the image survives a core reset. The read
    // below sees the pre-edge word, giving read-old-value on a same-cycle store.
    always_ff @(posedge clk) begin
        if (memwrite && ram_sel) begin
            mem[widx] <= writedata;
        end
    end

    assign leds_d  = led_we ? writedata[15:0] : leds_q;
    assign cycle_d = cycle_q + 32'd1;

    // CYCLE is read-only: stores to its offset are simply not decoded.
    always_ff @(posedge clk) begin
        if (reset) begin
            leds_q  <= '0;
            cycle_q <= '0;
        end else begin
            leds_q  <= leds_d;
            cycle_q <= cycle_d;
        end
    end

    mmio_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .load_we_i (tload_we),
        .ctrl_we_i (tctrl_we),
        .wdata_i   (writedata),
        .load_o    (tload_rd),
        .count_o   (tcount_rd),
        .ctrl_o    (tctrl_rd),
        .irq_o     (irq)
    );

    always_comb begin
        readdata = '0;
        if (ram_sel) begin
            readdata = mem[widx];
        end else if (mmio_sel) begin
            case (off)
                OFF_LED:    readdata = {16'd0, leds_q};
                OFF_CYCLE:  readdata = cycle_q;
                OFF_TLOAD:  readdata = tload_rd;
                OFF_TCOUNT: readdata = tcount_rd;
                OFF_TCTRL:  readdata = tctrl_rd;
                default:    readdata = '0;
            endcase
        end
    end

    assign leds = leds_q;

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] leds;
    logic        irq;

    int n_chk = 0;
    int n_bad = 0;

    dmem_mmio #(.DEPTH(64), .INIT_FILE(""), .MMIO_BASE(16'hFFFF)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .leds      (leds),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_ram [64];
    logic [15:0] m_leds;
    logic [31:0] m_cycle, m_load, m_count;
    logic        m_en, m_ar, m_exp, m_ie;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [7:0] o;
        o = a[7:0] & 8'hFC;
        if (a[31:16] == 16'hFFFF) begin
            if (o == 8'h00) return {16'd0, m_leds};
            if (o == 8'h04) return m_cycle;
            if (o == 8'h08) return m_load;
            if (o == 8'h0C) return m_count;
            if (o == 8'h10) return {28'd0, m_ie, m_exp, m_ar, m_en};
            return 32'd0;
        end
        if (a[31:2] < 30'd64) return m_ram[a[7:2]];
        return 32'd0;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [7:0]  o;
        logic        mw;
        logic [31:0] nc;
        logic        ne, na, nx, ni;
        o  = addr[7:0] & 8'hFC;
        mw = memwrite && (addr[31:16] == 16'hFFFF);
        if (reset) begin
            m_leds = 0; m_cycle = 0; m_load = 0; m_count = 0;
            m_en = 0; m_ar = 0; m_exp = 0; m_ie = 0;
        end else begin
            if (memwrite && addr[31:16] != 16'hFFFF && addr[31:2] < 30'd64)
                m_ram[addr[7:2]] = writedata;
            m_cycle = m_cycle + 1;
            if (mw && o == 8'h00) m_leds = writedata[15:0];
            ne = m_en; na = m_ar; nx = m_exp; ni = m_ie; nc = m_count;
            if (mw && o == 8'h10) begin
                ne = writedata[0]; na = writedata[1]; ni = writedata[3];
                if (writedata[2]) nx = 0;
            end
            if (ne && m_count > 1) nc = m_count - 1;
            else if (ne && m_count == 1) begin
                nx = 1;
                if (na) nc = m_load;
                else begin nc = 0; ne = 0; end
            end
            if (mw && o == 8'h08) begin m_load = writedata; nc = writedata; end
            m_count = nc; m_en = ne; m_ar = na; m_exp = nx; m_ie = ni;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rst);
        @(negedge clk);
        memwrite  = we;
        addr      = a;
        writedata = wd;
        reset     = rst;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [15:0] led;
        logic        irq;
    } vec_t;

    function automatic vec_t mkv(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rd, input logic [15:0] led, input logic irq_e);
        vec_t v;
        v.we = we; v.a = a; v.wd = wd; v.rd = rd; v.led = led; v.irq = irq_e;
        return v;
    endfunction

    vec_t vt[$];

    localparam logic [31:0] A_LED = 32'hFFFF_0000;
    localparam logic [31:0] A_CYC = 32'hFFFF_0004;
    localparam logic [31:0] A_TLD = 32'hFFFF_0008;
    localparam logic [31:0] A_TCN = 32'hFFFF_000C;
    localparam logic [31:0] A_TCT = 32'hFFFF_0010;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, wd;
        logic [7:0]  o;
        logic        we, rst;
        int          cls;

        // RAM with fresh store, unaligned read, out-of-range load/store.
        vt.push_back(mkv(1, 32'h10,  32'hDEADBEEF, 32'hA5A50004, 16'h0, 0));
        vt.push_back(mkv(0, 32'h10,  32'h0,        32'hDEADBEEF, 16'h0, 0));
        vt.push_back(mkv(0, 32'h13,  32'h0,        32'hDEADBEEF, 16'h0, 0));
        vt.push_back(mkv(0, 32'h100, 32'h0,        32'h0,        16'h0, 0));
        vt.push_back(mkv(1, 32'h100, 32'h55555555, 32'h0,        16'h0, 0));
        // LED register
        vt.push_back(mkv(1, A_LED, 32'h1234ABCD, 32'h0,        16'h0,    0));
        vt.push_back(mkv(0, A_LED, 32'h0,        32'h0000ABCD, 16'hABCD, 0));
        // one-shot timer with interrupt
        vt.push_back(mkv(1, A_TLD, 32'd3, 32'h0, 16'hABCD, 0));
        vt.push_back(mkv(1, A_TCT, 32'h9, 32'h0, 16'hABCD, 0));
        vt.push_back(mkv(0, A_TCN, 32'h0, 32'd2, 16'hABCD, 0));
        vt.push_back(mkv(0, A_TCN, 32'h0, 32'd1, 16'hABCD, 0));
        vt.push_back(mkv(0, A_TCN, 32'h0, 32'd0, 16'hABCD, 1));
        vt.push_back(mkv(0, A_TCT, 32'h0, 32'hC, 16'hABCD, 1));
        vt.push_back(mkv(1, A_TCT, 32'h4, 32'hC, 16'hABCD, 1));
        vt.push_back(mkv(0, A_TCT, 32'h0, 32'h0, 16'hABCD, 0));
        // auto-reload, load=2
        vt.push_back(mkv(1, A_TLD, 32'd2, 32'd3, 16'hABCD, 0));
        vt.push_back(mkv(1, A_TCT, 32'h3, 32'h0, 16'hABCD, 0));
        vt.push_back(mkv(0, A_TCN, 32'h0, 32'd1, 16'hABCD, 0));
        vt.push_back(mkv(0, A_TCN, 32'h0, 32'd2, 16'hABCD, 0));
        vt.push_back(mkv(0, A_TCN, 32'h0, 32'd1, 16'hABCD, 0));
        vt.push_back(mkv(0, A_TCN, 32'h0, 32'd2, 16'hABCD, 0));
        vt.push_back(mkv(0, A_TCT, 32'h0, 32'h7, 16'hABCD, 0));
        vt.push_back(mkv(0, A_TCN, 32'h0, 32'd2, 16'hABCD, 0));
        // W1C on the expiry cycle loses; W1C on a plain decrement cycle clears
        vt.push_back(mkv(1, A_TCT, 32'h7, 32'h7, 16'hABCD, 0));
        vt.push_back(mkv(1, A_TCT, 32'h7, 32'h7, 16'hABCD, 0));
        vt.push_back(mkv(0, A_TCT, 32'h0, 32'h3, 16'hABCD, 0));
        vt.push_back(mkv(0, A_TCT, 32'h0, 32'h7, 16'hABCD, 0));
        // LOAD write on a decrement cycle wins
        vt.push_back(mkv(0, A_TCN, 32'h0,  32'd1,  16'hABCD, 0));
        vt.push_back(mkv(1, A_TLD, 32'd10, 32'd2,  16'hABCD, 0));
        vt.push_back(mkv(0, A_TCN, 32'h0,  32'd10, 16'hABCD, 0));
        vt.push_back(mkv(0, A_TCN, 32'h0,  32'd9,  16'hABCD, 0));
        vt.push_back(mkv(1, A_TCT, 32'h0,  32'h7,  16'hABCD, 0));
        vt.push_back(mkv(0, A_TCT, 32'h0,  32'h4,  16'hABCD, 0));

        reset = 1'b1; memwrite = 1'b0; addr = '0; writedata = '0;
        for (int i = 0; i < 64; i++) m_ram[i] = 32'h0;

        // reset state
        apply(0, A_CYC, 0, 1); tick();
        apply(0, A_CYC, 0, 0);
        chk("reset cycle", readdata, 32'd0);
        chk("reset leds", {16'd0, leds}, 32'd0);
        chk("reset irq", {31'd0, irq}, 32'd0);
        tick();
        apply(0, A_TCT, 0, 0);
        chk("reset tctrl", readdata, 32'd0);
        tick();

        // known RAM contents
        for (int i = 0; i < 64; i++) begin
            apply(1, 32'(i * 4), 32'(i) ^ 32'hA5A50000, 0);
            tick();
        end

        for (int i = 0; i < vt.size(); i++) begin
            apply(vt[i].we, vt[i].a, vt[i].wd, 0);
            chk($sformatf("vec%0d rd", i), readdata, vt[i].rd);
            chk($sformatf("vec%0d leds", i), {16'd0, leds}, {16'd0, vt[i].led});
            chk($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, vt[i].irq});
            tick();
        end

        // every RAM word matches the model (out-of-range store touched nothing)
        for (int i = 0; i < 64; i++) begin
            apply(0, 32'(i * 4), 0, 0);
            chk($sformatf("ram word %0d", i), readdata, m_ram[i]);
            tick();
        end

        // reset mid-countdown clears LEDs, cycle and timer
        apply(1, A_TCT, 32'h1, 0); tick();
        apply(0, A_LED, 0, 1); tick();
        apply(0, A_CYC, 0, 0);
        chk("rst2 cycle", readdata, 32'd0);
        chk("rst2 leds", {16'd0, leds}, 32'd0);
        tick();
        apply(0, A_TCN, 0, 0);
        chk("rst2 tcount", readdata, 32'd0);
        tick();

        // CYCLE wrap; store to CYCLE ignored
        apply(0, A_CYC, 0, 0);
        force dut.cycle_d = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 release dut.cycle_d;
        model_step();
        m_cycle = 32'hFFFF_FFFF;
        apply(1, A_CYC, 32'h12345678, 0);
        chk("cycle max", readdata, 32'hFFFF_FFFF);
        tick();
        apply(0, A_CYC, 0, 0);
        chk("cycle wrap", readdata, 32'd0);
        tick();
        apply(0, A_CYC, 0, 0);
        chk("cycle after wrap", readdata, 32'd1);
        tick();

        // randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            we  = ($urandom_range(0, 1) == 1) && !rst;
            cls = $urandom_range(0, 3);
            wd  = $urandom;
            if (cls == 0) begin
                a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            end else if (cls == 1) begin
                a = $urandom;
                a[8] = 1'b1;
                a[16] = 1'b0;
            end else begin
                o = 8'($urandom_range(0, 6) * 4);
                a = {16'hFFFF, 8'h00, o} | 32'($urandom_range(0, 3));
                if (o == 8'h08) wd = 32'($urandom_range(0, 6));
                if (o == 8'h10) wd = 32'($urandom_range(0, 15));
            end
            apply(we, a, wd, rst);
            chk($sformatf("rnd%0d rd @%08h", n, a), readdata, model_read(a));
            chk($sformatf("rnd%0d leds", n), {16'd0, leds}, {16'd0, m_leds});
            chk($sformatf("rnd%0d irq", n), {31'd0, irq}, {31'd0, m_exp & m_ie});
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
